// File: rtl/dead_time_gen.sv
// Complementary half-bridge gate driver with programmable dead time and latched fault shutdown.
// Gate outputs are registered decodes of the FSM state, so hs and ls can never overlap.
module dead_time_gen #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clkm,
    input  logic            reset,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt,
    input  logic            fault,
    output logic            hs,
    output logic            ls,
    output logic            fault_flag
);

    typedef enum logic [2:0] {
        IDLE,
        DT_TO_HS,
        HS_ON,
        DT_TO_LS,
        LS_ON,
        FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nxt;
    logic            origin;
    logic            origin_nxt;
    logic [DT_W-1:0] dt_eff;

    // A zero dead time still guarantees one dead cycle.
    assign dt_eff = (dt == '0) ? DT_W'(1) : dt;

    // State, counter, origin and registered output decode.
    always_ff @(posedge clkm) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            origin     <= 1'b0;
            hs         <= 1'b0;
            ls         <= 1'b0;
            fault_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            origin     <= origin_nxt;
            hs         <= (state == HS_ON);
            ls         <= (state == LS_ON);
            fault_flag <= (state == FAULT);
        end
    end

    // Next-state logic; origin=1 means the dead time was entered from the opposite ON state.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        origin_nxt = origin;

        if (fault) begin
            state_nxt = FAULT;
        end else if (state == FAULT) begin
            if (!en) begin
                state_nxt = IDLE;
            end
        end else if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = pwm_in ? DT_TO_HS : DT_TO_LS;
                    cnt_nxt    = dt_eff;
                    origin_nxt = 1'b0;
                end
                HS_ON: begin
                    if (!pwm_in) begin
                        state_nxt  = DT_TO_LS;
                        cnt_nxt    = dt_eff;
                        origin_nxt = 1'b1;
                    end
                end
                LS_ON: begin
                    if (pwm_in) begin
                        state_nxt  = DT_TO_HS;
                        cnt_nxt    = dt_eff;
                        origin_nxt = 1'b1;
                    end
                end
                DT_TO_HS: begin
                    if (!pwm_in) begin
                        if (origin) begin
                            state_nxt = LS_ON;
                        end else begin
                            state_nxt = DT_TO_LS;
                            cnt_nxt   = dt_eff;
                        end
                    end else if (cnt <= DT_W'(1)) begin
                        state_nxt = HS_ON;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                DT_TO_LS: begin
                    if (pwm_in) begin
                        if (origin) begin
                            state_nxt = HS_ON;
                        end else begin
                            state_nxt = DT_TO_HS;
                            cnt_nxt   = dt_eff;
                        end
                    end else if (cnt <= DT_W'(1)) begin
                        state_nxt = LS_ON;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
